arf062b064e1r1w0cbbehsaa4acw_rd_port: RTL
=========================================

ARF062B064E1R1W0CBBEHSAA4ACW_RD_PORT -- requirements
Module: arf062b064e1r1w0cbbehsaa4acw_rd_port

Interface
REQ-001 SHALL have parameter DATA_W, default 62, array word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, array address width (64 entries).
REQ-003 SHALL have parameter RSP_DEPTH, default 3, response buffer entries.
REQ-004 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-005 SHALL have port rstb  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rd_req_vld  input  1  read request valid.
REQ-007 SHALL have port rd_req_rdy  output  1  request accepted when vld&rdy.
REQ-008 SHALL have port rd_adr  input  ADDR_W  request address.
REQ-009 SHALL have port rd_rsp_vld  output  1  response valid.
REQ-010 SHALL have port rd_rsp_rdy  input  1  consumer ready; pop when vld&rdy.
REQ-011 SHALL have port rd_rsp_data  output  DATA_W  response word.
REQ-012 SHALL have port arr_rd_en  output  1  array read strobe, combinational from rd_req_vld&rd_req_rdy.
REQ-013 SHALL have port arr_rd_adr  output  ADDR_W  array read address, equals rd_adr.
REQ-014 SHALL have port arr_rd_data  input  DATA_W  array read data, valid cycle after arr_rd_en.
REQ-015 SHALL have ports wr_en input 1, wr_adr input ADDR_W, wr_data input DATA_W: write-port snoop.

Function
REQ-016 SHALL accept at most one request per cycle; accept at cycle N drives arr_rd_en at N.
REQ-017 SHALL hold one-bit inflight flag set at accept, cleared next cycle unless new accept.
REQ-018 SHALL push arr_rd_data into response buffer at end of cycle N+1; rd_rsp_vld asserts at N+2 (latency 2).
REQ-019 SHALL drive rd_req_rdy = ready_q & (occupancy + inflight < RSP_DEPTH), no dependence on rd_rsp_rdy.
REQ-020 SHALL sustain 1 request/cycle when rd_rsp_rdy held high.
REQ-021 SHALL return responses strictly in request order.
REQ-022 SHALL drive rd_rsp_data from buffer head; stable while rd_rsp_vld & !rd_rsp_rdy.
REQ-023 SHALL handle simultaneous push and pop in one cycle with occupancy unchanged; pop on empty impossible by construction.
REQ-024 SHALL never overflow: push only occurs for a credited request.
REQ-025 SHALL wrap buffer read/write pointers modulo RSP_DEPTH.

Reset
REQ-026 SHALL asynchronously clear inflight, occupancy, pointers, ready_q on rstb low.
REQ-027 SHALL drive rd_req_rdy=0, rd_rsp_vld=0, arr_rd_en=0, rd_rsp_data=0 during reset.
REQ-028 SHALL set ready_q one clk after rstb deasserts; rd_req_rdy=1 from second edge.
REQ-029 SHALL discard any inflight read and buffered data on reset mid-operation; no stale response afterward.

Configuration
REQ-030 SHALL, with ARF062B064E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN defined, register wr_data and a hit flag when wr_en & wr_adr==arr_rd_adr in an accept cycle, and push wr_data instead of arr_rd_data.
REQ-031 SHALL, without the macro, always push arr_rd_data (read-before-write: old value); snoop ports unused.

Structure
REQ-032 SHALL place DATA_W/ADDR_W/RSP_DEPTH defaults and typedefs rd_word_t, rd_adr_t in package arf062b064e1r1w0cbbehsaa4acw_rd_pkg.
REQ-033 SHALL implement response buffer as sub-module arf062b064e1r1w0cbbehsaa4acw_rd_fifo (flop-based, push/pop/occupancy).

Verification
REQ-034 Reset release, vld=0 -> rdy=0 first edge, 1 second edge; rsp_vld=0.
REQ-035 Single read adr=0x05, array data 0x2A_AAAA_AAAA_AAAA -> arr_rd_en cycle N, rsp_vld cycle N+2 with that data.
REQ-036 Back-to-back reads adr 0..9, rsp_rdy=1 -> rdy never drops, 10 in-order responses, one per cycle.
REQ-037 rsp_rdy=0, vld held -> exactly 3 accepts then rdy=0; releasing rsp_rdy drains 3 in order, rdy returns.
REQ-038 Read adr=0x3F with same-cycle write 0x3F data 0x1 (old 0x0) -> response 0x1 with macro, 0x0 without.
REQ-039 rstb low while 2 buffered + 1 inflight -> all outputs 0 immediately; after release no response appears.

Source files
------------

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_rd_pkg.sv
// Shared sizing defaults and word/address types for the array read port.
// Optional feature macro used by the port: ARF062B064E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN.
package arf062b064e1r1w0cbbehsaa4acw_rd_pkg;

    localparam int RD_DATA_W    = 62;
    localparam int RD_ADDR_W    = 6;
    localparam int RD_RSP_DEPTH = 3;

    typedef logic [RD_DATA_W-1:0] rd_word_t;
    typedef logic [RD_ADDR_W-1:0] rd_adr_t;

    // Bits needed to hold an occupancy count of 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_rd_fifo.sv
// Flop-based response buffer: push/pop with occupancy, pointers wrap modulo DEPTH.
module arf062b064e1r1w0cbbehsaa4acw_rd_fifo
    import arf062b064e1r1w0cbbehsaa4acw_rd_pkg::*;
#(
    parameter int DATA_W = RD_DATA_W,
    parameter int DEPTH  = RD_RSP_DEPTH,
    localparam int OCC_W = occ_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [OCC_W-1:0]  o_occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [OCC_W-1:0]  r_occ;

    // Storage is cleared too so the head reads zero after any reset.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head = r_mem[r_rptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_rd_port.sv
// Credit-gated array read port with 2-cycle latency and in-order response buffer.
// Optional write-snoop bypass: ARF062B064E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN.
module arf062b064e1r1w0cbbehsaa4acw_rd_port
    import arf062b064e1r1w0cbbehsaa4acw_rd_pkg::*;
#(
    parameter int DATA_W    = RD_DATA_W,
    parameter int ADDR_W    = RD_ADDR_W,
    parameter int RSP_DEPTH = RD_RSP_DEPTH
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              rd_req_vld,
    output logic              rd_req_rdy,
    input  logic [ADDR_W-1:0] rd_adr,
    output logic              rd_rsp_vld,
    input  logic              rd_rsp_rdy,
    output logic [DATA_W-1:0] rd_rsp_data,
    output logic              arr_rd_en,
    output logic [ADDR_W-1:0] arr_rd_adr,
    input  logic [DATA_W-1:0] arr_rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int OCC_W = occ_width(RSP_DEPTH);
    localparam int CRD_W = OCC_W + 1;

    logic              r_ready;
    logic              r_inflight;
    logic              w_accept;
    logic              w_pop;
    logic [OCC_W-1:0]  w_occ;
    logic [CRD_W-1:0]  w_credits_used;
    logic [DATA_W-1:0] w_push_data;

    // The in-flight read already owns a buffer slot, so it counts against credit.
    assign w_credits_used = CRD_W'(w_occ) + CRD_W'(r_inflight);
    assign rd_req_rdy     = r_ready & (w_credits_used < CRD_W'(RSP_DEPTH));
    assign w_accept       = rd_req_vld & rd_req_rdy;
    assign arr_rd_en      = w_accept;
    assign arr_rd_adr     = rd_adr;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ready    <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_ready    <= 1'b1;
            r_inflight <= w_accept;
        end
    end

`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN
    logic              r_hit;
    logic [DATA_W-1:0] r_wr_data;

    // A same-cycle write to the address being read wins over the array's old value.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_hit     <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_hit <= w_accept & wr_en & (wr_adr == rd_adr);
            if (w_accept) begin
                r_wr_data <= wr_data;
            end
        end
    end

    assign w_push_data = r_hit ? r_wr_data : arr_rd_data;
`else
    logic w_unused_snoop;
    assign w_unused_snoop = ^{wr_en, wr_adr, wr_data};
    assign w_push_data    = arr_rd_data;
`endif

    assign w_pop      = rd_rsp_vld & rd_rsp_rdy;
    assign rd_rsp_vld = (w_occ != '0);

    arf062b064e1r1w0cbbehsaa4acw_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rstb        (rstb),
        .i_push      (r_inflight),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (rd_rsp_data),
        .o_occ       (w_occ)
    );

endmodule
